// File: rtl/bt_msg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bt_msg_arbiter_if
// Description : Source request/message bus plus send_8byte sender handshake
//               as seen by bt_msg_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bt_msg_arbiter_if;
    logic [3:0]   req;
    logic [255:0] msg_data;
    logic [3:0]   ack;
    logic [3:0]   sent;
    logic         send_en;
    logic [63:0]  send_data;
    logic         send_done;
    logic         busy;
    logic         timeout;

    modport master (
        input  req, msg_data, send_done,
        output ack, sent, send_en, send_data, busy, timeout
    );

    modport slave (
        output req, msg_data, send_done,
        input  ack, sent, send_en, send_data, busy, timeout
    );
endinterface
`default_nettype wire

// File: rtl/bt_msg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bt_msg_arbiter
// Description : Round-robin arbiter/sequencer feeding one 64-bit message at a
//               time to the send_8byte UART sender, with a post-message gap.
//               Optional watchdog in WAIT_DONE: define BT_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bt_msg_arbiter #(
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    bt_msg_arbiter_if.master bus
);
    localparam int c_GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_ptr, w_ptr_nxt;
    logic [1:0]         r_grant, w_grant_nxt;
    logic [63:0]        r_send_data, w_send_data_nxt;
    logic [3:0]         r_ack, w_ack_nxt;
    logic [3:0]         r_sent, w_sent_nxt;
    logic               r_send_en, w_send_en_nxt;
    logic               r_timeout, w_timeout_nxt;
    logic [c_GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
    logic               r_done_q;
    logic               w_done_rise;
    logic               w_wd_expired;
    logic               w_req_hit;
    logic [1:0]         w_req_sel;

    assign w_done_rise = bus.send_done & ~r_done_q;

    // First requester strictly after the last served source, wrapping at 4.
    always_comb begin
        w_req_hit = 1'b0;
        w_req_sel = r_ptr;
        for (int i = 1; i <= 4; i++) begin
            if (!w_req_hit && bus.req[r_ptr + 2'(i)]) begin
                w_req_hit = 1'b1;
                w_req_sel = r_ptr + 2'(i);
            end
        end
    end

`ifdef BT_ARB_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WD_W-1:0] r_wd_cnt;

    always_ff @(posedge clk) begin
        if (rst || (r_state != S_WAIT_DONE)) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
        end
    end

    assign w_wd_expired = (r_state == S_WAIT_DONE) &&
                          (r_wd_cnt == c_WD_W'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog: the limit is never reached.
    assign w_wd_expired = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_grant_nxt     = r_grant;
        w_send_data_nxt = r_send_data;
        w_ack_nxt       = 4'b0000;
        w_sent_nxt      = 4'b0000;
        w_send_en_nxt   = r_send_en;
        w_timeout_nxt   = 1'b0;
        w_gap_cnt_nxt   = r_gap_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req_hit) begin
                    w_grant_nxt     = w_req_sel;
                    w_send_data_nxt = bus.msg_data[{w_req_sel, 6'd0} +: 64];
                    w_ack_nxt       = 4'b0001 << w_req_sel;
                    w_state_nxt     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_send_en_nxt = 1'b1;
                w_state_nxt   = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (w_done_rise) begin
                    w_send_en_nxt = 1'b0;
                    w_sent_nxt    = 4'b0001 << r_grant;
                    w_ptr_nxt     = r_grant;
                    w_gap_cnt_nxt = c_GAP_W'(GAP_CYCLES);
                    w_state_nxt   = S_GAP;
                end else if (w_wd_expired) begin
                    w_send_en_nxt = 1'b0;
                    w_timeout_nxt = 1'b1;
                    w_ptr_nxt     = r_grant;
                    w_gap_cnt_nxt = c_GAP_W'(GAP_CYCLES);
                    w_state_nxt   = S_GAP;
                end
            end
            S_GAP: begin
                // A loaded count of 0 or 1 both spend exactly one cycle here.
                if (r_gap_cnt <= c_GAP_W'(1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - c_GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'd3;
            r_grant     <= 2'd0;
            r_send_data <= 64'd0;
            r_ack       <= 4'b0000;
            r_sent      <= 4'b0000;
            r_send_en   <= 1'b0;
            r_timeout   <= 1'b0;
            r_gap_cnt   <= '0;
            r_done_q    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_grant     <= w_grant_nxt;
            r_send_data <= w_send_data_nxt;
            r_ack       <= w_ack_nxt;
            r_sent      <= w_sent_nxt;
            r_send_en   <= w_send_en_nxt;
            r_timeout   <= w_timeout_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_done_q    <= bus.send_done;
        end
    end

    assign bus.ack       = r_ack;
    assign bus.sent      = r_sent;
    assign bus.send_en   = r_send_en;
    assign bus.send_data = r_send_data;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.timeout   = r_timeout;
endmodule
`default_nettype wire

// File: tb/tb_bt_msg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bt_msg_arbiter
// Description : Self-checking bench for bt_msg_arbiter with a behavioural
//               send_8byte model and a round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bt_msg_arbiter;
    localparam int c_GAP = 16;
    localparam int c_TMO = 100;
    localparam logic [63:0] c_FREQ = 64'h4652455131323334;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bt_msg_arbiter_if bus ();

    logic sd_model;
    logic sd_manual;
    assign bus.send_done = sd_model | sd_manual;

    bt_msg_arbiter #(
        .GAP_CYCLES     (c_GAP),
        .TIMEOUT_CYCLES (c_TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int max);
        for (int i = 0; i < max && bus.ack == 4'b0000; i++) tick();
    endtask

    task automatic wait_sent(input int max);
        for (int i = 0; i < max && bus.sent == 4'b0000; i++) tick();
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max && bus.busy; i++) tick();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = 4'b0000;
        repeat (3) tick();
        rst     = 1'b0;
    endtask

    function automatic logic [63:0] msg_of(input int i);
        return 64'h534F555243453030 + 64'(i);
    endfunction

    // Reference arbitration rule: first requester after the last served one.
    function automatic logic [3:0] rr_pick(input int last, input logic [3:0] r);
        for (int j = 1; j <= 4; j++) begin
            if (r[(last + j) % 4]) return 4'b0001 << ((last + j) % 4);
        end
        return 4'b0000;
    endfunction

    // Sender model: done some cycles after each rising send_en.
    int   sd_delay = 5;
    int   sd_len   = 1;
    bit   sd_rand  = 1'b0;
    bit   sd_mute  = 1'b0;
    int   sd_cnt   = -1;
    int   sd_hold  = 0;
    logic sd_en_p  = 1'b0;

    initial begin
        sd_model = 1'b0;
        forever begin
            tick();
            if (!bus.send_en) begin
                sd_cnt = -1;
            end else if (!sd_en_p) begin
                sd_cnt = sd_mute ? -1 : (sd_rand ? int'($urandom_range(20, 1)) : sd_delay);
            end else if (sd_cnt > 0) begin
                sd_cnt--;
                if (sd_cnt == 0) begin
                    sd_hold = sd_rand ? int'($urandom_range(3, 1)) : sd_len;
                    sd_cnt  = -1;
                end
            end
            sd_model = (sd_hold > 0);
            if (sd_hold > 0) sd_hold--;
            sd_en_p = bus.send_en;
        end
    end

    // Continuous invariants on the sender-facing side.
    int          low_cnt     = 1000;
    int          n_rise      = 0;
    int          n_sent_seen = 0;
    int          n_tmo_seen  = 0;
    logic [63:0] en_data;
    bit          en_data_bad = 1'b0;
    logic        en_pm       = 1'b0;

    initial begin
        forever begin
            tick();
            if (rst) low_cnt = 1000;
            if (bus.send_en) begin
                if (!en_pm) begin
                    check("en_low_window", 64'(low_cnt >= c_GAP + 1), 1);
                    n_rise++;
                    en_data     = bus.send_data;
                    en_data_bad = 1'b0;
                end else if (bus.send_data !== en_data) begin
                    en_data_bad = 1'b1;
                end
                low_cnt = 0;
            end else begin
                if (en_pm) check("en_data_stable", 64'(en_data_bad), 0);
                if (low_cnt < 1000) low_cnt++;
            end
            if (bus.ack != 4'b0000) check("ack_onehot", 64'($onehot(bus.ack)), 1);
            if (bus.sent != 4'b0000) begin
                check("sent_onehot", 64'($onehot(bus.sent)), 1);
                n_sent_seen++;
            end
            if (bus.timeout) n_tmo_seen++;
            en_pm = bus.send_en;
        end
    end

    typedef struct {
        logic [3:0] req;
        logic [1:0] grant;
    } vec_t;

    vec_t        tv [12];
    logic        acc_busy, acc_en, acc_ack, acc_sent;
    int          cnt, n_sent0, rise0;
    int          model_ptr, out_idx, n_req, n_ack, n_sent_r, idx;
    bit          outstanding;
    logic [3:0]  req_applied, exp_mask, dropped;
    logic [63:0] rmsg [4];

    initial begin
        tv[0]  = '{4'b1111, 2'd0};
        tv[1]  = '{4'b1111, 2'd1};
        tv[2]  = '{4'b1111, 2'd2};
        tv[3]  = '{4'b1111, 2'd3};
        tv[4]  = '{4'b1111, 2'd0};
        tv[5]  = '{4'b0100, 2'd2};
        tv[6]  = '{4'b0011, 2'd0};
        tv[7]  = '{4'b1010, 2'd1};
        tv[8]  = '{4'b1001, 2'd3};
        tv[9]  = '{4'b1001, 2'd0};
        tv[10] = '{4'b1000, 2'd3};
        tv[11] = '{4'b0110, 2'd1};

        sd_manual = 1'b0;
        for (int i = 0; i < 4; i++) bus.msg_data[64*i +: 64] = msg_of(i);
        do_reset();

        // Reset values, then an idle stretch with a stray done pulse.
        check("rst_send_data", bus.send_data, 0);
        check("rst_timeout", 64'(bus.timeout), 0);
        acc_busy = 0; acc_en = 0; acc_ack = 0; acc_sent = 0;
        for (int i = 0; i < 20; i++) begin
            sd_manual = (i == 5 || i == 6);
            tick();
            acc_busy |= bus.busy;
            acc_en   |= bus.send_en;
            acc_ack  |= |bus.ack;
            acc_sent |= |bus.sent;
        end
        sd_manual = 1'b0;
        check("idle_busy", 64'(acc_busy), 0);
        check("idle_send_en", 64'(acc_en), 0);
        check("idle_ack", 64'(acc_ack), 0);
        check("idle_sent", 64'(acc_sent), 0);

        // Single source with a 40-cycle sender.
        sd_delay = 40;
        sd_len   = 2;
        bus.msg_data[191:128] = c_FREQ;
        bus.req = 4'b0100;
        tick();
        check("single_ack", bus.ack, 4'b0100);
        check("single_data", bus.send_data, c_FREQ);
        check("single_en_lag", 64'(bus.send_en), 0);
        bus.req = 4'b0000;
        tick();
        check("single_en", 64'(bus.send_en), 1);
        check("single_ack_width", bus.ack, 0);
        n_sent0 = n_sent_seen;
        wait_sent(200);
        check("single_sent", bus.sent, 4'b0100);
        check("single_data_hold", bus.send_data, c_FREQ);
        bus.req = 4'b0100;
        cnt = 0;
        for (int i = 0; i < 100 && bus.ack == 4'b0000; i++) begin
            tick();
            cnt++;
        end
        check("single_regrant", bus.ack, 4'b0100);
        check("single_gap_min", 64'(cnt >= c_GAP + 1), 1);
        check("single_gap_max", 64'(cnt <= c_GAP + 3), 1);
        check("single_sent_once", 64'(n_sent_seen - n_sent0), 1);
        bus.req = 4'b0000;
        wait_sent(200);
        wait_idle(100);

        // Table: rotating priority from reset.
        for (int i = 0; i < 4; i++) bus.msg_data[64*i +: 64] = msg_of(i);
        sd_delay = 5;
        sd_len   = 1;
        do_reset();
        rise0 = n_rise;
        for (int r = 0; r < 12; r++) begin
            bus.req = tv[r].req;
            wait_ack(200);
            check($sformatf("tbl%0d_ack", r), bus.ack, 4'b0001 << tv[r].grant);
            check($sformatf("tbl%0d_data", r), bus.send_data, msg_of(int'(tv[r].grant)));
            bus.req = tv[r].req & ~bus.ack;
            wait_sent(200);
            check($sformatf("tbl%0d_sent", r), bus.sent, 4'b0001 << tv[r].grant);
        end
        check("tbl_en_rises", 64'(n_rise - rise0), 12);
        bus.req = 4'b0000;
        wait_idle(100);

        // Request pulsed for one cycle during a transfer is dropped.
        bus.req = 4'b0001;
        wait_ack(50);
        check("drop_owner_ack", bus.ack, 4'b0001);
        bus.req = 4'b0000;
        for (int i = 0; i < 10 && !bus.send_en; i++) tick();
        tick();
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b0000;
        acc_ack = 0; acc_sent = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            acc_ack  |= bus.ack[1];
            acc_sent |= bus.sent[0];
        end
        check("drop_no_ack", 64'(acc_ack), 0);
        check("drop_owner_sent", 64'(acc_sent), 1);

        // Reset while waiting for done.
        sd_delay = 40;
        bus.req  = 4'b0010;
        wait_ack(50);
        for (int i = 0; i < 10 && !bus.send_en; i++) tick();
        repeat (3) tick();
        n_sent0 = n_sent_seen;
        rst = 1'b1;
        tick();
        check("rst_en_drop", 64'(bus.send_en), 0);
        check("rst_busy", 64'(bus.busy), 0);
        tick();
        tick();
        rst = 1'b0;
        wait_ack(50);
        check("rst_reack", bus.ack, 4'b0010);
        check("rst_no_sent", 64'(n_sent_seen - n_sent0), 0);
        bus.req = 4'b0000;
        wait_sent(200);
        check("rst_sent_after", bus.sent, 4'b0010);
        wait_idle(100);

`ifdef BT_ARB_TIMEOUT_EN
        sd_mute = 1'b1;
        bus.req = 4'b1000;
        wait_ack(50);
        bus.req = 4'b0001;
        for (int i = 0; i < 10 && !bus.send_en; i++) tick();
        n_sent0 = n_sent_seen;
        cnt = 0;
        for (int i = 0; i < 300 && !bus.timeout; i++) begin
            tick();
            cnt++;
        end
        check("tmo_latency", 64'(cnt), 64'(c_TMO));
        check("tmo_en_drop", 64'(bus.send_en), 0);
        sd_mute = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100 && bus.ack == 4'b0000; i++) begin
            tick();
            cnt++;
        end
        check("tmo_next_grant", bus.ack, 4'b0001);
        check("tmo_gap_min", 64'(cnt >= c_GAP + 1), 1);
        check("tmo_no_sent", 64'(n_sent_seen - n_sent0), 0);
        bus.req = 4'b0000;
        wait_sent(200);
        wait_idle(100);
`else
        check("no_timeout_pulse", 64'(n_tmo_seen), 0);
`endif

        // Random traffic against the reference model.
        sd_rand = 1'b1;
        do_reset();
        model_ptr = 3; outstanding = 0; out_idx = 0;
        n_req = 0; n_ack = 0; n_sent_r = 0;
        req_applied = 4'b0000;
        for (int c = 0; c < 1600; c++) begin
            tick();
            dropped = 4'b0000;
            if (bus.ack != 4'b0000) begin
                exp_mask = rr_pick(model_ptr, req_applied);
                check("rnd_ack", bus.ack, exp_mask);
                check("rnd_ack_while_busy", 64'(outstanding), 0);
                idx = 0;
                for (int j = 0; j < 4; j++) if (exp_mask[j]) idx = j;
                check("rnd_data", bus.send_data, rmsg[idx]);
                outstanding = 1'b1;
                out_idx     = idx;
                n_ack++;
                bus.req[idx] = 1'b0;
                dropped[idx] = 1'b1;
            end
            if (bus.sent != 4'b0000) begin
                check("rnd_sent", bus.sent, 4'b0001 << out_idx);
                check("rnd_sent_outstanding", 64'(outstanding), 1);
                model_ptr   = out_idx;
                outstanding = 1'b0;
                n_sent_r++;
            end
            if (c < 1300) begin
                for (int j = 0; j < 4; j++) begin
                    if (!bus.req[j] && !dropped[j] && $urandom_range(7, 0) == 0) begin
                        rmsg[j] = {$urandom, $urandom};
                        bus.msg_data[64*j +: 64] = rmsg[j];
                        bus.req[j] = 1'b1;
                        n_req++;
                    end
                end
            end
            req_applied = bus.req;
        end
        check("rnd_all_acked", 64'(n_ack), 64'(n_req));
        check("rnd_all_sent", 64'(n_sent_r), 64'(n_ack));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL sim_watchdog: got unfinished, want finished by %0t", $time);
        $fatal(1, "simulation watchdog expired");
    end
endmodule
`default_nettype wire
